one_hot_rr_scheduler: RTL and testbench
=======================================

// Module: one_hot_rr_scheduler
// PURPOSE
//   Round-robin scheduler that shares one resource among N requesters.
//   Each grant is issued as a binary index and as its one-hot decode, so
//   downstream muxes and enables can use whichever form they need.
//   A grant is held until the owner signals done, or until a hold timeout
//   forces it off. Sits between the requester bank and the shared datapath.
// PARAMETERS
//   N        32  number of requesters; 2 <= N <= 2**IDX_W
//   IDX_W    5   width of the binary grant index
//   MAX_HOLD 16  maximum cycles a grant may be held before forced release (>=1)
//   CNT_W    5   hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   req_i         in   N      request vector, bit k = requester k
//   done_i        in   1      owner releases the grant (sampled only in GRANT)
//   grant_valid_o out  1      a grant is active
//   grant_idx_o   out  IDX_W  binary index of the owner; 0 when no grant
//   grant_o       out  N      one-hot grant, equal to 1<<grant_idx_o when valid,
//                             all-zero otherwise
//   timeout_o     out  1      one-cycle pulse on a forced release
// BEHAVIOUR
//   - Reset (async assert, sync deassert at the clk edge): state=IDLE, ptr=0,
//     hold_cnt=0, grant_valid_o=0, grant_idx_o=0, grant_o=0, timeout_o=0.
//   - All outputs are registered, with no combinational input->output path.
//   - FSM IDLE:
//       - if |req_i, pick the first set bit searching ptr, ptr+1, ..., N-1,
//         0, ..., ptr-1.
//       - Next cycle: state=GRANT, grant_idx_o=winner, grant_o=onehot(winner),
//         grant_valid_o=1, hold_cnt=0.
//       - If req_i==0, stay in IDLE.
//   - FSM GRANT:
//       - The grant is held regardless of req_i; a dropped request does not
//         release it.
//       - Each cycle without done_i, hold_cnt increments.
//       - Release is taken when done_i=1, or when hold_cnt==MAX_HOLD-1 with
//         done_i=0 (forced).
//       - Next cycle after release: state=IDLE, all grant outputs zero, and
//         ptr = (owner==N-1) ? 0 : owner+1.
//       - timeout_o=1 for that one cycle only when the release was forced.
//       - done_i and the timeout in the same cycle count as a normal release
//         (timeout_o=0).
//   - Latency:
//       - Request seen in IDLE at edge t -> grant visible after edge t+1.
//       - done_i at edge t -> grant drops after t+1, and the next grant
//         appears after t+2. The one idle gap cycle is mandatory.
//   - A grant lasts at most MAX_HOLD cycles.
//   - Fairness: a continuously asserting requester is granted within N grants.
//   - done_i in IDLE is ignored.
//   - Request bits at index >= N do not exist; the search wraps at N-1, not
//     at 2**IDX_W-1.
//   - Reset asserted mid-grant clears all outputs immediately (async), and
//     ptr returns to 0.
// TESTING
//   1. Reset: rst_n=0 with req_i=all-ones -> all outputs 0. After release,
//      first grant idx=0, grant_o=32'h1.
//   2. Round-robin: req_i=32'hFFFF_FFFF, done_i pulsed one cycle after each
//      grant -> idx sequence 0,1,2,...,31,0, with one-cycle gaps; grant_o
//      always 1<<idx.
//   3. Wrap/ptr: ptr=30 (after granting 29), req_i=bits{3,29} -> grant 3.
//      Then with req_i=bits{3,29} still set -> grant 29.
//   4. Timeout: MAX_HOLD=16, req_i=bit5, done_i=0 -> grant held exactly 16
//      cycles, timeout_o pulses once, then re-grant 5 after one idle cycle.
//   5. Sticky grant: grant to 7, req_i drops to 0 -> grant_o=bit7 held until
//      done_i, then IDLE with outputs 0 and ptr=8.
//   6. Async reset mid-grant: assert rst_n=0 between clock edges during a
//      grant -> outputs 0 without waiting for clk. Next grant searches from
//      index 0.

Source files
------------

// File: rtl/one_hot_rr_scheduler.sv
// one_hot_rr_scheduler
//   Round-robin scheduler that shares one resource among N requesters.
//   Each grant is presented both as a binary index and as its one-hot
//   decode. A grant is held until the owner raises done_i, or until it has
//   been held MAX_HOLD cycles, at which point it is forcibly released and
//   timeout_o pulses for one cycle. Every release is followed by exactly
//   one idle cycle before the next grant can appear.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req_i   [N]    request vector, bit k = requester k
//   done_i         owner releases the grant (ignored when no grant is active)
//   grant_valid_o  a grant is active
//   grant_idx_o    binary index of the owner, 0 when no grant
//   grant_o [N]    one-hot grant, 1<<grant_idx_o when valid, else zero
//   timeout_o      one-cycle pulse following a forced release
module one_hot_rr_scheduler #(
  parameter int N        = 32,
  parameter int IDX_W    = 5,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic [N-1:0]     grant_o,
  output logic             timeout_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [N-1:0]     hi_mask;
  logic [N-1:0]     req_hi;
  logic [IDX_W-1:0] pick_idx;
  logic             hold_last;

  // Index of the lowest set bit of v (0 when v is zero).
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Circular search starting at ptr: requests at or above ptr win first;
  // if none, the search wraps to the lowest request below ptr. Only bits
  // 0..N-1 exist, so the wrap happens at N-1.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (IDX_W'(i) >= ptr);
    end
    req_hi   = req_i & hi_mask;
    pick_idx = (|req_hi) ? lowest_idx(req_hi) : lowest_idx(req_i);
  end

  assign hold_last = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Registered FSM and outputs: nothing from the inputs reaches an output
  // without passing through this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      grant_valid_o <= 1'b0;
      grant_idx_o   <= '0;
      grant_o       <= '0;
      timeout_o     <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_i) begin
            state         <= ST_GRANT;
            grant_valid_o <= 1'b1;
            grant_idx_o   <= pick_idx;
            grant_o       <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            hold_cnt      <= '0;
          end
        end
        ST_GRANT: begin
          // A dropped request never releases the grant; only done_i or
          // the hold limit do. done_i wins over a coincident timeout.
          if (done_i || hold_last) begin
            state         <= ST_IDLE;
            grant_valid_o <= 1'b0;
            grant_idx_o   <= '0;
            grant_o       <= '0;
            hold_cnt      <= '0;
            timeout_o     <= !done_i;
            ptr           <= (grant_idx_o == IDX_W'(N - 1)) ? '0
                                                            : grant_idx_o + IDX_W'(1);
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_one_hot_rr_scheduler.sv
module tb_one_hot_rr_scheduler;

  localparam int N        = 32;
  localparam int IDX_W    = 5;
  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 5;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_i;
  logic             done_i;
  logic             grant_valid_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic [N-1:0]     grant_o;
  logic             timeout_o;

  typedef struct {
    logic             v;
    logic [IDX_W-1:0] idx;
    logic             to;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  one_hot_rr_scheduler #(
    .N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .done_i       (done_i),
    .grant_valid_o(grant_valid_o),
    .grant_idx_o  (grant_idx_o),
    .grant_o      (grant_o),
    .timeout_o    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input int idx, input logic to);
    exp_t e;
    e.v = 1'b1; e.idx = IDX_W'(idx); e.to = to;
    sb.push_back(e);
  endtask

  task automatic push_idle(input logic to);
    exp_t e;
    e.v = 1'b0; e.idx = '0; e.to = to;
    sb.push_back(e);
  endtask

  task automatic observe(input string tag);
    exp_t         e;
    logic [N-1:0] eg;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, nothing expected", tag);
      return;
    end
    e  = sb.pop_front();
    eg = e.v ? ({{(N-1){1'b0}}, 1'b1} << e.idx) : '0;
    assert (grant_valid_o === e.v && grant_idx_o === e.idx &&
            grant_o === eg && timeout_o === e.to)
    else begin
      failures++;
      $error("FAIL %s observed v=%b idx=%0d grant=%h to=%b expected v=%b idx=%0d grant=%h to=%b",
             tag, grant_valid_o, grant_idx_o, grant_o, timeout_o,
             e.v, e.idx, eg, e.to);
    end
  endtask

  initial begin
    // 1. reset with every requester asking
    rst_n  = 1'b0;
    req_i  = '1;
    done_i = 1'b0;
    #1;
    push_idle(1'b0); observe("reset_async");
    step(); step(); step();
    push_idle(1'b0); observe("reset_held");
    rst_n = 1'b1;
    step();
    push_grant(0, 1'b0); observe("first_grant");

    // 2. round-robin over all requesters with a gap after each release
    for (int k = 0; k < 32; k++) begin
      done_i = 1'b1;
      step();
      push_idle(1'b0); observe("rr_gap");
      done_i = 1'b0;
      step();
      push_grant((k + 1) % 32, 1'b0); observe("rr_grant");
    end

    // 3. pointer wrap: grant 29 so ptr becomes 30, then bits {3,29}
    req_i  = 32'h2000_0000;
    done_i = 1'b1;
    step(); push_idle(1'b0); observe("wrap_gap0");
    done_i = 1'b0;
    step(); push_grant(29, 1'b0); observe("wrap_g29");
    req_i  = 32'h2000_0008;
    done_i = 1'b1;
    step(); push_idle(1'b0); observe("wrap_gap1");
    done_i = 1'b0;
    step(); push_grant(3, 1'b0); observe("wrap_g3");
    done_i = 1'b1;
    step(); push_idle(1'b0); observe("wrap_gap2");
    done_i = 1'b0;
    step(); push_grant(29, 1'b0); observe("wrap_g29_again");

    // 4. forced release after MAX_HOLD cycles
    req_i  = 32'h0000_0020;
    done_i = 1'b1;
    step(); push_idle(1'b0); observe("to_gap0");
    done_i = 1'b0;
    step(); push_grant(5, 1'b0); observe("to_hold_first");
    for (int c = 1; c < MAX_HOLD; c++) begin
      step(); push_grant(5, 1'b0); observe("to_hold");
    end
    step(); push_idle(1'b1); observe("to_pulse");
    step(); push_grant(5, 1'b0); observe("to_regrant");
    // done_i coincident with the hold limit is a normal release
    for (int c = 1; c < MAX_HOLD; c++) begin
      step(); push_grant(5, 1'b0); observe("to_hold2");
    end
    done_i = 1'b1;
    step(); push_idle(1'b0); observe("to_done_same_cycle");
    done_i = 1'b0;

    // 5. sticky grant after the request drops
    req_i = 32'h0000_0080;
    step(); push_grant(7, 1'b0); observe("sticky_g7");
    req_i = '0;
    for (int c = 0; c < 3; c++) begin
      step(); push_grant(7, 1'b0); observe("sticky_hold");
    end
    done_i = 1'b1;
    step(); push_idle(1'b0); observe("sticky_release");
    step(); push_idle(1'b0); observe("done_in_idle");
    step(); push_idle(1'b0); observe("done_in_idle2");
    done_i = 1'b0;
    req_i  = 32'h0000_0140;
    step(); push_grant(8, 1'b0); observe("sticky_ptr8");

    // 6. asynchronous reset in the middle of a grant
    req_i = 32'h4000_0100;
    step(); push_grant(8, 1'b0); observe("async_pre");
    #2;
    rst_n = 1'b0;
    #1;
    push_idle(1'b0); observe("async_clear");
    rst_n = 1'b1;
    step(); push_grant(8, 1'b0); observe("async_ptr0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
